shift_right_seq_16b: RTL and testbench

- Multi-cycle right-shift unit for the 16-bit datapath; it complements the combinational shift-left-by-one block.
- Performs logical or arithmetic right shift of a 16-bit operand by 0-15 places, one bit per clock.
- Uses a start/busy/done handshake so control can issue srl/sra and stall until the result is ready.
- Also reports the last bit shifted out for flag logic.

---
 rtl/shift_right_seq_16b.sv | 113 +++++++++++
 tb/tb_shift_right_seq_16b.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq_16b.sv
// Multi-cycle right shifter: logical or arithmetic shift of a WIDTH-bit
// operand by 0..2^AMT_W-1 places, one place per clock, behind a
// start/busy/done handshake. Also reports the last bit shifted out.
module shift_right_seq_16b #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] amt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [AMT_W-1:0]   cnt_q,   cnt_d;
    logic               mode_q,  mode_d;
    logic               c_q,     c_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   out_q,   out_d;
    logic               cout_q,  cout_d;

    // Next-state logic: capture on start, shift while cnt != 0, publish at cnt == 0.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; an unassigned path in always_comb infers a latch.
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;   // done is a single-cycle pulse
        out_d   = out_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = in;
                    cnt_d   = amt;
                    mode_d  = arith;
                    c_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    // Fill bit is the current MSB for arithmetic mode, which
                    // keeps replicating the captured sign bit on every step.
                    data_d = {mode_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    c_d    = data_q[0];
                    cnt_d  = cnt_q - AMT_W'(1);
                end else begin
                    out_d   = data_q;
                    cout_d  = c_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight shift.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values, independent of statement order.
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_shift_right_seq_16b.sv
// Directed bench for shift_right_seq_16b: reset, logical/arithmetic shifts,
// amt=0 and amt=15 boundaries, ignored start while busy, back-to-back ops
// and asynchronous abort.
module tb_shift_right_seq_16b;

    logic        CLK;
    logic        Reset_n;
    logic        start;
    logic [15:0] in;
    logic [3:0]  amt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        cout;

    int total = 0;
    int bad   = 0;

    shift_right_seq_16b #(.WIDTH(16), .AMT_W(4)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .start   (start),
        .in      (in),
        .amt     (amt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .cout    (cout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        Reset_n = 1'b0;
        start   = 1'b0;
        in      = 16'h0;
        amt     = 4'h0;
        arith   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({busy, done, out, cout} !== 19'h0) begin
            bad++;
            $display("FAIL reset_held: busy=%b done=%b out=%h cout=%b, want all zero",
                     busy, done, out, cout);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        @(posedge CLK);
        #1;
        total++;
        if ({busy, done, out, cout} !== 19'h0) begin
            bad++;
            $display("FAIL reset_release: busy=%b done=%b out=%h cout=%b, want all zero",
                     busy, done, out, cout);
        end
    endtask

    // One operation with start held one cycle; inputs are scrambled after acceptance.
    task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic ar,
                          input logic [15:0] exp_out, input logic exp_cout, input string name);
        int k;
        bit seen;
        @(negedge CLK);
        in = a; amt = n; arith = ar; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0; in = ~a; amt = ~n; arith = ~ar;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s_accept: busy=%b done=%b, want busy=1 done=0", name, busy, done);
        end
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge CLK);
            #1;
            k++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_busy: busy=%b at edge %0d, want 1", name, busy, k);
                end
            end
        end
        total++;
        if (!seen || k != int'(n) + 1) begin
            bad++;
            $display("FAIL %s_latency: done seen=%0d after %0d edges, want after %0d",
                     name, seen, k, int'(n) + 1);
        end
        total++;
        if (out !== exp_out) begin
            bad++;
            $display("FAIL %s_out: got %h, want %h", name, out, exp_out);
        end
        total++;
        if (cout !== exp_cout) begin
            bad++;
            $display("FAIL %s_cout: got %b, want %b", name, cout, exp_cout);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done: got %b, want 0", name, busy);
        end
        @(posedge CLK);
        #1;
        total++;
        if (done !== 1'b0 || out !== exp_out || cout !== exp_cout) begin
            bad++;
            $display("FAIL %s_after_done: done=%b out=%h cout=%b, want 0 %h %b",
                     name, done, out, cout, exp_out, exp_cout);
        end
    endtask

    task automatic test_srl();
        run_op(16'h8004, 4'd2, 1'b0, 16'h2001, 1'b0, "srl2");
    endtask

    task automatic test_sra();
        run_op(16'h8004, 4'd3,  1'b1, 16'hF000, 1'b1, "sra3");
        run_op(16'h8000, 4'd15, 1'b1, 16'hFFFF, 1'b0, "sra15");
    endtask

    task automatic test_boundaries();
        run_op(16'hFFFF, 4'd15, 1'b0, 16'h0001, 1'b1, "srl15");
        run_op(16'h1234, 4'd0,  1'b0, 16'h1234, 1'b0, "amt0");
    endtask

    // Second start arrives while the first shift is in flight and must be dropped.
    task automatic test_ignore_busy();
        int ndone = 0;
        int dk = 0;
        logic [15:0] got_out = 16'h0;
        logic got_cout = 1'b0;
        @(negedge CLK);
        in = 16'h00F0; amt = 4'd4; arith = 1'b0; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                @(negedge CLK);
                in = 16'hAAAA; amt = 4'd1; start = 1'b1;
            end
            @(posedge CLK);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                dk = k;
                got_out = out;
                got_cout = cout;
            end
        end
        total++;
        if (ndone != 1 || dk != 5) begin
            bad++;
            $display("FAIL ignore_done: %0d pulses, last at edge %0d, want 1 pulse at edge 5",
                     ndone, dk);
        end
        total++;
        if (got_out !== 16'h000F || got_cout !== 1'b0) begin
            bad++;
            $display("FAIL ignore_result: out=%h cout=%b, want 000f 0", got_out, got_cout);
        end
    endtask

    // start held high: a new op is accepted in every done cycle.
    task automatic test_back_to_back();
        int ndone = 0;
        int last_k = 0;
        @(negedge CLK);
        in = 16'h0008; amt = 4'd3; arith = 1'b0; start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge CLK);
            #1;
            total++;
            if (busy !== ~done) begin
                bad++;
                $display("FAIL b2b_busy: edge %0d busy=%b done=%b, want busy=~done", k, busy, done);
            end
            if (done === 1'b1) begin
                ndone++;
                total++;
                if (k != last_k + 5) begin
                    bad++;
                    $display("FAIL b2b_spacing: done at edge %0d, want %0d", k, last_k + 5);
                end
                last_k = k;
                total++;
                if (out !== 16'h0001 || cout !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_result: out=%h cout=%b, want 0001 0", out, cout);
                end
            end
        end
        @(negedge CLK);
        start = 1'b0;
        total++;
        if (ndone != 5) begin
            bad++;
            $display("FAIL b2b_count: got %0d done pulses, want 5", ndone);
        end
        repeat (2) @(posedge CLK);
    endtask

    // Reset dropped between edges in the middle of a shift.
    task automatic test_async_abort();
        int ndone = 0;
        @(negedge CLK);
        in = 16'hFFFF; amt = 4'd10; arith = 1'b1; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, out, cout} !== 19'h0) begin
            bad++;
            $display("FAIL abort_clear: busy=%b done=%b out=%h cout=%b, want all zero",
                     busy, done, out, cout);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge CLK);
            #1;
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0 || busy !== 1'b0 || out !== 16'h0) begin
            bad++;
            $display("FAIL abort_no_done: pulses=%0d busy=%b out=%h, want 0 0 0000",
                     ndone, busy, out);
        end
    endtask

    initial begin
        test_reset();
        test_srl();
        test_sra();
        test_boundaries();
        test_ignore_busy();
        test_back_to_back();
        test_async_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
